cwe1280_fixed_reg: RTL and testbench
====================================

# cwe1280_fixed_reg

Access-controlled data register: an 8-bit register that only an authorized user ID may write. The access check is evaluated in the same cycle as the write, so an unauthorized request never reaches the register, not even for one cycle. This is the fixed counterpart of the CWE-1280 pattern, where a stale grant lets a write slip through. It sits between a shared requester bus (user ID plus write data) and a protected asset whose value is exported on `data_out`.

## Interface
Parameters:
- `DATA_W`, default 8: width of `data_in` and `data_out`.
- `ID_W`, default 3: width of `usr_id`.
- `AUTH_ID`, default 3'h4: the single user ID allowed to write.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `usr_id`, input, `ID_W`: ID of the requester presenting data this cycle.
- `data_in`, input, `DATA_W`: candidate write data.
- `data_out`, output, `DATA_W`: current register contents (registered output).

## Operation
- Grant is combinational in the current cycle: `grant = (usr_id == AUTH_ID)`. It must never be a registered or previous-cycle grant.
- Rising edge with `grant` = 1: the register loads `data_in`.
- Rising edge with `grant` = 0: the register holds its value. The unauthorized `data_in` is discarded with no partial or bytewise update.
- There is no separate write strobe. Every cycle with an authorized ID presented is a write.
- Consecutive authorized cycles each overwrite the register.
- `data_out` is always the register contents. There is no bypass from `data_in` to `data_out`.
- X or Z on `usr_id` must not enable a write. The compare is equality only, and the synthesized result of a non-matching ID is hold.

## Timing
- Reset: while `rst` = 1, `data_out` = 0. Reset asserts immediately, without waiting for a clock edge, and overrides any write in progress.
- Release: the first rising edge after `rst` falls can perform a write.
- Latency: data presented with an authorized ID appears on `data_out` one edge later, after the same rising edge that samples it.
- ID switch from authorized to unauthorized between edges: the write depends only on the `usr_id` value sampled at that edge. The previous cycle's grant has no effect.
- ID switch from unauthorized to authorized: a write occurs on that same edge, with no dead cycle.
- Reset asserted mid-stream: `data_out` goes to 0 at once, and subsequent unauthorized cycles keep it at 0.

## Structure
- Shared package `cwe1280_pkg`:
  - default `DATA_W`, `ID_W`
  - `AUTH_ID` constant
  - a `usr_id_t` typedef
- Sub-module `cwe1280_access_check`: purely combinational, `usr_id` in, `grant` out. It is kept separate so the policy can be reviewed and formally checked in isolation.
- Top level: the access-check instance plus one register with asynchronous reset and a load enable.

## Test plan
- Reset: drive `rst` = 1 with `data_in` = 8'hFF and `usr_id` = 4 -> `data_out` = 8'h00 with no clock edge required; it stays 0 while reset is held.
- Authorized write: after release, `usr_id` = 4 and `data_in` = 8'hAB for one edge -> `data_out` = 8'hAB.
- Blocked write: next cycle `usr_id` = 3 and `data_in` = 8'hCD -> `data_out` stays 8'hAB.
- Blocked again: `usr_id` = 3 and `data_in` = 8'hEF -> `data_out` stays 8'hAB. Sweep all IDs other than 4 with random data -> no change.
- Back-to-back authorized writes: `usr_id` = 4 with 8'h11 then 8'h22 on consecutive edges -> `data_out` = 8'h11 then 8'h22. Switching to `usr_id` = 5 on the next edge holds 8'h22.
- Asynchronous reset mid-stream: assert `rst` between edges while `data_out` = 8'h22 -> `data_out` = 8'h00 immediately. After release, `usr_id` = 3 keeps it at 0, and `usr_id` = 4 with 8'h5A loads 8'h5A.

Source files
------------

// File: rtl/cwe1280_pkg.sv
// cwe1280_pkg: shared widths, the authorized requester ID and the user-ID type
// for the access-controlled data register.
`default_nettype none

package cwe1280_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ID_W   = 3;

  typedef logic [DEFAULT_ID_W-1:0] usr_id_t;

  localparam usr_id_t DEFAULT_AUTH_ID = 3'h4;

endpackage

`default_nettype wire

// File: rtl/cwe1280_access_check.sv
// cwe1280_access_check: combinational write-permission policy, grant only for AUTH_ID.
// Rev 1.0 - initial release
`default_nettype none

module cwe1280_access_check
  import cwe1280_pkg::*;
#(
  parameter int              ID_W    = DEFAULT_ID_W,
  parameter logic [ID_W-1:0] AUTH_ID = ID_W'(DEFAULT_AUTH_ID)
) (
  input  logic [ID_W-1:0] usr_id,
  output logic            grant
);

  // Same-cycle equality only: an unknown or non-matching ID never yields a grant.
  assign grant = (usr_id == AUTH_ID);

endmodule

`default_nettype wire

// File: rtl/cwe1280_fixed_reg.sv
// cwe1280_fixed_reg: 8-bit asset register writable only by AUTH_ID, grant checked on the write edge.
// Rev 1.0 - initial release
`default_nettype none

module cwe1280_fixed_reg
  import cwe1280_pkg::*;
#(
  parameter int              DATA_W  = DEFAULT_DATA_W,
  parameter int              ID_W    = DEFAULT_ID_W,
  parameter logic [ID_W-1:0] AUTH_ID = ID_W'(DEFAULT_AUTH_ID)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   usr_id,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic              w_grant;
  logic [DATA_W-1:0] r_data;

  cwe1280_access_check #(
    .ID_W    (ID_W),
    .AUTH_ID (AUTH_ID)
  ) u_access_check (
    .usr_id (usr_id),
    .grant  (w_grant)
  );

  // The grant is never registered, so a stale permission cannot carry a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_grant) begin
      r_data <= data_in;
    end
  end

  assign data_out = r_data;

endmodule

`default_nettype wire

// File: tb/tb_cwe1280_fixed_reg.sv
// tb_cwe1280_fixed_reg: scoreboard bench for the access-controlled data register.
`timescale 1ns/1ps
`default_nettype none

module tb_cwe1280_fixed_reg;

  localparam int         DATA_W = 8;
  localparam int         ID_W   = 3;
  localparam logic [2:0] AUTH   = 3'h4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   usr_id;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model;
  logic [DATA_W-1:0] exp_q[$];

  cwe1280_fixed_reg #(
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .AUTH_ID (AUTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .usr_id   (usr_id),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: data_out=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, data_out=%h expected=<none>", tag, data_out);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, data_out, e);
    end
  endtask

  // Present one request, update the reference model, and check after the edge.
  task automatic drive_cycle(input string tag, input logic [ID_W-1:0] id,
                             input logic [DATA_W-1:0] d);
    usr_id  = id;
    data_in = d;
    if (id == AUTH) model = d;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: data_out=%h expected=end of test", data_out);
    $fatal(1, "timeout");
  end

  initial begin
    model   = '0;
    usr_id  = AUTH;
    data_in = 8'hFF;
    rst     = 1'b1;
    #1;
    exp_q.push_back(8'h00);
    pop_check("reset_async");
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(8'h00);
    pop_check("reset_held");
    rst = 1'b0;

    drive_cycle("auth_write_ab", AUTH, 8'hAB);
    drive_cycle("blocked_cd", 3'd3, 8'hCD);
    drive_cycle("blocked_ef", 3'd3, 8'hEF);
    for (int id = 0; id < 8; id++) begin
      if (id[ID_W-1:0] != AUTH)
        drive_cycle($sformatf("sweep_id%0d", id), id[ID_W-1:0],
                    DATA_W'($urandom_range(0, 255)));
    end

    drive_cycle("b2b_11", AUTH, 8'h11);
    drive_cycle("b2b_22", AUTH, 8'h22);
    drive_cycle("switch_to_5_holds", 3'd5, 8'h77);
    drive_cycle("unauth_to_auth_33", 3'd1, 8'h99);
    drive_cycle("auth_same_edge_33", AUTH, 8'h33);
    drive_cycle("auth_then_unauth", 3'd6, 8'h44);

    // Assert reset between edges while a write request is pending.
    drive_cycle("preload_22", AUTH, 8'h22);
    #3;
    rst   = 1'b1;
    model = '0;
    #1;
    exp_q.push_back(model);
    pop_check("reset_midstream");
    @(posedge clk);
    #1;
    exp_q.push_back(model);
    pop_check("reset_overrides_write");
    rst = 1'b0;

    drive_cycle("post_reset_unauth", 3'd3, 8'hC3);
    drive_cycle("post_reset_auth_5a", AUTH, 8'h5A);
    drive_cycle("final_hold", 3'd0, 8'hA5);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
